// File: rtl/tsg_seq_ctrl_pkg.sv
// Shared TSG control definitions: controller state encoding and the
// helper that sizes the test-pattern index counter.
package tsg_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLR       = 3'd1,
        ST_WAIT_SYND = 3'd2,
        ST_EMIT      = 3'd3,
        ST_DONE      = 3'd4
    } ctr_state_e;

    localparam int TP_NUM_DEFAULT = 4;

    // Smallest index width w with 2^w > num-1 (never below 1).
    function automatic int tp_cnt_w(input int num);
        int w;
        w = 1;
        while ((1 << w) < num) w++;
        return w;
    endfunction

endpackage

// File: rtl/tsg_seq_ctrl.sv
// Sequencing controller for the Chase test-syndrome generator: clears the TSG,
// loads the hard-decision syndromes, then steps through TEST_PAT_NUM patterns.
module tsg_seq_ctrl
    import tsg_seq_ctrl_pkg::*;
#(
    parameter int TEST_PAT_NUM = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             in_ctr_rst_n,
    input  logic             in_ctr_start,
    input  logic             in_ctr_abort,
    input  logic             in_ctr_synd_vld,
    output logic             out_ctr_synd_rdy,
    input  logic             in_ctr_dn_rdy,
    output logic             out_ctr_ts_vld,
    output logic [CNT_W-1:0] out_tp_idx,
    output logic             out_tsg_Srst,
    output logic             out_tsg_en,
    output logic             out_tsg_init,
    output logic             out_tsg_TSG_en,
    output logic             out_ctr_busy,
    output logic             out_ctr_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TEST_PAT_NUM - 1);

    ctr_state_e       state_q;
    logic [CNT_W-1:0] tp_idx_q;
    logic             busy_q;
    logic             synd_rdy_q;
    logic             ts_vld_q;
    logic             srst_clr_q;
    logic             done_q;

    logic accept;
    logic xfer;
    logic last;

    // Abort overrides both handshakes so no strobe can fire in the abort cycle.
    assign accept = synd_rdy_q & in_ctr_synd_vld & ~in_ctr_abort;
    assign xfer   = ts_vld_q & in_ctr_dn_rdy & ~in_ctr_abort;
    assign last   = (tp_idx_q == LAST_IDX);

    assign out_ctr_synd_rdy = synd_rdy_q;
    assign out_ctr_ts_vld   = ts_vld_q;
    assign out_tp_idx       = tp_idx_q;
    assign out_ctr_busy     = busy_q;
    assign out_ctr_done     = done_q;
    assign out_tsg_Srst     = srst_clr_q | (in_ctr_abort & busy_q);
    assign out_tsg_init     = accept;
    assign out_tsg_TSG_en   = xfer & ~last;
    assign out_tsg_en       = accept | (xfer & ~last);

    always_ff @(posedge clk or negedge in_ctr_rst_n) begin
        if (!in_ctr_rst_n) begin
            state_q    <= ST_IDLE;
            tp_idx_q   <= '0;
            busy_q     <= 1'b0;
            synd_rdy_q <= 1'b0;
            ts_vld_q   <= 1'b0;
            srst_clr_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            srst_clr_q <= 1'b0;
            done_q     <= 1'b0;
            if (busy_q && in_ctr_abort) begin
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                synd_rdy_q <= 1'b0;
                ts_vld_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (in_ctr_start) begin
                            state_q    <= ST_CLR;
                            busy_q     <= 1'b1;
                            srst_clr_q <= 1'b1;
                        end
                    end
                    ST_CLR: begin
                        state_q    <= ST_WAIT_SYND;
                        synd_rdy_q <= 1'b1;
                    end
                    ST_WAIT_SYND: begin
                        if (accept) begin
                            state_q    <= ST_EMIT;
                            synd_rdy_q <= 1'b0;
                            ts_vld_q   <= 1'b1;
                            tp_idx_q   <= '0;
                        end
                    end
                    ST_EMIT: begin
                        if (xfer) begin
                            if (last) begin
                                state_q  <= ST_DONE;
                                ts_vld_q <= 1'b0;
                                done_q   <= 1'b1;
                            end else begin
                                tp_idx_q <= tp_idx_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        synd_rdy_q <= 1'b0;
                        ts_vld_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tsg_seq_ctrl.sv
// Scoreboard bench for tsg_seq_ctrl: the driver pushes the pattern/done events
// a codeword must produce; a negedge monitor pops them as the DUT presents them.
module tb_tsg_seq_ctrl;
    import tsg_seq_ctrl_pkg::*;

    localparam int N     = TP_NUM_DEFAULT;
    localparam int CW    = 3;
    localparam int DONE_TOK = -1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          synd_vld = 1'b0;
    logic          synd_rdy;
    logic          dn_rdy = 1'b0;
    logic          ts_vld;
    logic [CW-1:0] tp_idx;
    logic          srst, en, init, tsg_en, busy, done;

    int checks = 0;
    int errors = 0;
    int sb[$];

    always #5 clk = ~clk;

    tsg_seq_ctrl #(.TEST_PAT_NUM(N), .CNT_W(CW)) dut (
        .clk             (clk),
        .in_ctr_rst_n    (rst_n),
        .in_ctr_start    (start),
        .in_ctr_abort    (abort),
        .in_ctr_synd_vld (synd_vld),
        .out_ctr_synd_rdy(synd_rdy),
        .in_ctr_dn_rdy   (dn_rdy),
        .out_ctr_ts_vld  (ts_vld),
        .out_tp_idx      (tp_idx),
        .out_tsg_Srst    (srst),
        .out_tsg_en      (en),
        .out_tsg_init    (init),
        .out_tsg_TSG_en  (tsg_en),
        .out_ctr_busy    (busy),
        .out_ctr_done    (done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: consumes scoreboard entries on transfers and done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (init && tsg_en) chk("init_tsgen_exclusive", 1, 0);
            if (ts_vld && dn_rdy && !abort) begin
                if (sb.size() == 0) begin
                    chk("unexpected_transfer", int'(tp_idx), -99);
                end else begin
                    int e;
                    e = sb.pop_front();
                    chk("xfer_idx", int'(tp_idx), e);
                    chk("xfer_tsg_en", int'(tsg_en), (e != N - 1) ? 1 : 0);
                    chk("xfer_en", int'(en), (e != N - 1) ? 1 : 0);
                end
            end else if (ts_vld) begin
                chk("stall_strobes", int'({en, init, tsg_en}), 0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    int e;
                    e = sb.pop_front();
                    chk("done_token", e, DONE_TOK);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // dn_mode: 0 random, 1 pattern 1,0,0,1,1,0,1, 2 always ready.
    // abort_idx: -1 none, else abort in the first EMIT cycle presenting that index.
    task automatic run_cw(input int dn_mode, input int abort_idx, input int id);
        int m;
        int cyc;
        int k;
        logic [6:0] pat;
        pat = 7'b1011001;  // read LSB first: 1,0,0,1,1,0,1
        step();
        start = 1'b1;
        abort = 1'($urandom % 2);
        mid();
        chk("idle_busy", int'(busy), 0);
        chk("idle_srst", int'(srst), 0);
        step();
        start = 1'b0;
        abort = 1'b0;
        mid();
        chk("clr_srst", int'(srst), 1);
        chk("clr_busy", int'(busy), 1);
        chk("clr_synd_rdy", int'(synd_rdy), 0);
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
            step();
            mid();
            chk("wait_synd_rdy", int'(synd_rdy), 1);
            chk("wait_srst", int'(srst), 0);
            chk("wait_en", int'(en), 0);
        end
        step();
        synd_vld = 1'b1;
        for (int i = 0; i < N; i++) sb.push_back(i);
        sb.push_back(DONE_TOK);
        mid();
        chk("accept_init", int'(init), 1);
        chk("accept_en", int'(en), 1);
        chk("accept_tsg_en", int'(tsg_en), 0);
        m = 0;
        cyc = 0;
        while (m < N) begin
            step();
            synd_vld = 1'b0;
            start = 1'($urandom % 2);
            case (dn_mode)
                1:       dn_rdy = (cyc < 7) ? pat[cyc] : 1'b1;
                2:       dn_rdy = 1'b1;
                default: dn_rdy = (cyc > 200) ? 1'b1 : 1'($urandom % 2);
            endcase
            if (m == abort_idx) begin
                abort = 1'b1;
                dn_rdy = 1'b1;
                sb.delete();
                mid();
                chk("abort_srst", int'(srst), 1);
                chk("abort_tsg_en", int'(tsg_en), 0);
                chk("abort_en", int'(en), 0);
                step();
                abort = 1'b0;
                start = 1'b0;
                dn_rdy = 1'b0;
                mid();
                chk("post_abort_busy", int'(busy), 0);
                chk("post_abort_done", int'(done), 0);
                chk("post_abort_vld", int'(ts_vld), 0);
                $display("codeword %0d aborted at idx %0d", id, m);
                return;
            end
            mid();
            chk("emit_vld", int'(ts_vld), 1);
            chk("emit_idx", int'(tp_idx), m);
            if (dn_rdy) m++;
            cyc++;
        end
        step();
        start = 1'b0;
        dn_rdy = 1'b0;
        mid();
        chk("done_pulse", int'(done), 1);
        chk("done_vld", int'(ts_vld), 0);
        chk("done_busy", int'(busy), 1);
        step();
        mid();
        chk("idle_after_busy", int'(busy), 0);
        chk("idle_after_done", int'(done), 0);
        chk("idx_hold", int'(tp_idx), N - 1);
        $display("codeword %0d complete in %0d emit cycles", id, cyc);
    endtask

    task automatic reset_in_wait();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        mid();
        chk("rst_pre_synd_rdy", int'(synd_rdy), 1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_outputs", int'({synd_rdy, ts_vld, tp_idx, srst, en, init, tsg_en, busy, done}), 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            mid();
            chk("rst_stay_idle", int'(busy), 0);
            chk("rst_no_srst", int'(srst), 0);
        end
        $display("reset during WAIT_SYND handled");
    endtask

    initial begin
        mid();
        chk("reset_outputs", int'({synd_rdy, ts_vld, tp_idx, srst, en, init, tsg_en, busy, done}), 0);
        step();
        rst_n = 1'b1;
        run_cw(2, -1, 0);
        run_cw(1, -1, 1);
        run_cw(2, 2, 2);
        reset_in_wait();
        for (int i = 3; i < 25; i++) begin
            run_cw(0, ($urandom % 4 == 0) ? int'($urandom_range(0, N - 1)) : -1, i);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
        end
        step();
        mid();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
